// File: rtl/gol_editor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gol_editor_pkg
// Description : Shared types for the game-of-life editor, core and visualiser.
//               Holds the editor state encoding, the default grid size and
//               the cell-index helper that fixes the grid bit ordering.
// Revision    : 1.0 - initial release
// ============================================================================
package gol_editor_pkg;

    typedef enum logic [1:0] {
        PAUSED   = 2'd0,
        RUNNING  = 2'd1,
        SNAPSHOT = 2'd2
    } edit_state_t;

    localparam int c_grid_w_def = 16;
    localparam int c_grid_h_def = 16;

    // Grid bit ordering shared by every block: row-major, bit y*w + x.
    function automatic int unsigned idx(input int unsigned x,
                                        input int unsigned y,
                                        input int unsigned w);
        return y * w + x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gol_editor_if.sv
`default_nettype none
// ============================================================================
// Module      : gol_editor_if
// Description : Board-side bundle of the editor: raw buttons and the core's
//               live grid in, edited grid / run flag / cursor out.
//               master : board + core side (drives buttons and live_grid)
//               slave  : gol_editor
// Revision    : 1.0 - initial release
// ============================================================================
interface gol_editor_if #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16
);
    localparam int c_cells = GRID_W * GRID_H;
    localparam int c_xw    = $clog2(GRID_W);
    localparam int c_yw    = $clog2(GRID_H);

    logic                btn_left;
    logic                btn_right;
    logic                btn_up;
    logic                btn_down;
    logic                btn_toggle;
    logic                btn_run;
    logic                btn_clear;
    logic [c_cells-1:0]  live_grid;
    logic [c_cells-1:0]  grid_out;
    logic                paused;
    logic [c_xw-1:0]     sel_x;
    logic [c_yw-1:0]     sel_y;
    logic                cell_alive;
    logic                ctrl_update;

    modport master (
        output btn_left, btn_right, btn_up, btn_down,
        output btn_toggle, btn_run, btn_clear, live_grid,
        input  grid_out, paused, sel_x, sel_y, cell_alive, ctrl_update
    );

    modport slave (
        input  btn_left, btn_right, btn_up, btn_down,
        input  btn_toggle, btn_run, btn_clear, live_grid,
        output grid_out, paused, sel_x, sel_y, cell_alive, ctrl_update
    );

endinterface
`default_nettype wire

// File: rtl/gol_editor_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : One push-button conditioner: 2-flop synchroniser, debounce
//               counter and a one-cycle press pulse on the debounced rising
//               edge. With AUTOREPEAT_EN defined and REPEAT_EN set, a held
//               button emits further presses after REPEAT_DELAY cycles and
//               then every REPEAT_PERIOD cycles.
// Ports       : clk, rst_n  - clock, async active-low reset
//               i_btn       - raw asynchronous button, active-high
//               o_press     - one-cycle press pulse
// Macro       : AUTOREPEAT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
`ifdef AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);
    localparam int                c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_press;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level, so any bounce back to the old level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rep_w   = $clog2(c_rep_max + 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_rep_first;
    logic               r_repeat;

    // Counts cycles of a steady high level; the edge that raises the level
    // also restarts the count, so the first repeat lands REPEAT_DELAY cycles
    // after the original press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
            r_repeat    <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (!REPEAT_EN || !r_level) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if (r_rep_first ? (r_rep_cnt == c_rep_w'(REPEAT_DELAY - 1))
                                     : (r_rep_cnt == c_rep_w'(REPEAT_PERIOD - 1))) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
                r_repeat    <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press | r_repeat;
`else
    assign o_press = r_press;
`endif

endmodule
`default_nettype wire

// File: rtl/gol_editor.sv
`default_nettype none
// ============================================================================
// Module      : gol_editor
// Description : Upstream control stage for the game-of-life core. Turns raw
//               buttons into a paused/running flag, a cursor and an edited
//               grid image; snapshots the core's live grid on stop.
// Ports       : clk, rst_n     - clock, async active-low reset
//               bus (slave)    - buttons, live_grid in; grid_out, paused,
//                                sel_x, sel_y, cell_alive, ctrl_update out
// Macro       : AUTOREPEAT_EN  - auto-repeat on held direction buttons
// Revision    : 1.0 - initial release
// ============================================================================
module gol_editor
    import gol_editor_pkg::*;
#(
    parameter int GRID_W          = c_grid_w_def,
    parameter int GRID_H          = c_grid_h_def,
    parameter int DEBOUNCE_CYCLES = 250000
`ifdef AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    gol_editor_if.slave  bus
);
    localparam int c_cells = GRID_W * GRID_H;
    localparam int c_xw    = $clog2(GRID_W);
    localparam int c_yw    = $clog2(GRID_H);
    localparam int c_idx_w = $clog2(c_cells);
    localparam logic [c_xw-1:0] c_x_max = c_xw'(GRID_W - 1);
    localparam logic [c_yw-1:0] c_y_max = c_yw'(GRID_H - 1);

    // Button order: 0 left, 1 right, 2 up, 3 down, 4 toggle, 5 run, 6 clear.
    // Only the four direction buttons are allowed to auto-repeat.
    logic [6:0] w_btn_raw;
    logic [6:0] w_press;

    assign w_btn_raw = {bus.btn_clear, bus.btn_run, bus.btn_toggle,
                        bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};

    for (genvar i = 0; i < 7; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (i < 4)
`endif
        ) u_btn (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (w_btn_raw[i]),
            .o_press (w_press[i])
        );
    end

    edit_state_t          r_state;
    edit_state_t          w_state_next;
    logic [c_cells-1:0]   r_grid;
    logic [c_cells-1:0]   w_grid_next;
    logic [c_xw-1:0]      r_sel_x;
    logic [c_xw-1:0]      w_x_next;
    logic [c_yw-1:0]      r_sel_y;
    logic [c_yw-1:0]      w_y_next;
    logic                 r_ctrl_update;
    logic                 w_upd_next;
    logic [c_idx_w-1:0]   w_cur_idx;

    assign w_cur_idx = c_idx_w'(idx(32'(r_sel_x), 32'(r_sel_y), 32'(GRID_W)));

    // Priority clear > run > toggle; the cursor is handled separately so a
    // move still applies alongside run or clear. Toggle indexes with the
    // registered (pre-move) cursor.
    always_comb begin
        w_state_next = r_state;
        w_grid_next  = r_grid;
        w_upd_next   = 1'b0;
        case (r_state)
            PAUSED: begin
                if (w_press[6]) begin
                    w_grid_next = '0;
                    w_upd_next  = 1'b1;
                end else if (w_press[5]) begin
                    w_state_next = RUNNING;
                end else if (w_press[4]) begin
                    w_grid_next[w_cur_idx] = ~r_grid[w_cur_idx];
                    w_upd_next             = 1'b1;
                end
            end
            RUNNING: begin
                if (w_press[6]) begin
                    w_state_next = PAUSED;
                    w_grid_next  = '0;
                    w_upd_next   = 1'b1;
                end else if (w_press[5]) begin
                    w_state_next = SNAPSHOT;
                    w_grid_next  = bus.live_grid;
                end
            end
            SNAPSHOT: begin
                // Presses in this cycle are dropped; the pulse announces the
                // snapshot taken on the previous edge.
                w_state_next = PAUSED;
                w_upd_next   = 1'b1;
            end
            default: begin
                w_state_next = PAUSED;
            end
        endcase
    end

    always_comb begin
        w_x_next = r_sel_x;
        w_y_next = r_sel_y;
        if (r_state != SNAPSHOT) begin
            if (w_press[1] && !w_press[0]) begin
                w_x_next = (r_sel_x == c_x_max) ? '0 : r_sel_x + 1'b1;
            end else if (w_press[0] && !w_press[1]) begin
                w_x_next = (r_sel_x == '0) ? c_x_max : r_sel_x - 1'b1;
            end
            if (w_press[3] && !w_press[2]) begin
                w_y_next = (r_sel_y == c_y_max) ? '0 : r_sel_y + 1'b1;
            end else if (w_press[2] && !w_press[3]) begin
                w_y_next = (r_sel_y == '0) ? c_y_max : r_sel_y - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= PAUSED;
            r_grid        <= '0;
            r_sel_x       <= '0;
            r_sel_y       <= '0;
            r_ctrl_update <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_grid        <= w_grid_next;
            r_sel_x       <= w_x_next;
            r_sel_y       <= w_y_next;
            r_ctrl_update <= w_upd_next;
        end
    end

    assign bus.grid_out    = r_grid;
    assign bus.paused      = (r_state != RUNNING);
    assign bus.sel_x       = r_sel_x;
    assign bus.sel_y       = r_sel_y;
    assign bus.cell_alive  = r_grid[w_cur_idx];
    assign bus.ctrl_update = r_ctrl_update;

endmodule
`default_nettype wire

// File: tb/tb_gol_editor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gol_editor
// Description : Self-checking bench for gol_editor on an 8x4 grid. Button
//               actions are applied as raw held/bouncing levels; an abstract
//               model of the editor (grid array, cursor, run flag) predicts
//               the outputs after each action.
// Macro       : AUTOREPEAT_EN - also checks held-button repeat timing
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_editor;
    localparam int W = 8;
    localparam int H = 4;
    localparam int D = 4;
    localparam int N = W * H;
`ifdef AUTOREPEAT_EN
    localparam int RD = 20;
    localparam int RP = 6;
`endif

    // Mask bits: 0 left, 1 right, 2 up, 3 down, 4 toggle, 5 run, 6 clear.
    localparam logic [6:0] c_l = 7'h01, c_r = 7'h02, c_u = 7'h04, c_d = 7'h08;
    localparam logic [6:0] c_t = 7'h10, c_run = 7'h20, c_clr = 7'h40;
    localparam logic [31:0] c_hold = 32'h0000_003F;   // 6 cycles steady high
    localparam logic [31:0] c_bounce = 32'h0000_03F3; // 1,1,0,0 then 6 high

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gol_editor_if #(.GRID_W(W), .GRID_H(H)) bus ();

    gol_editor #(
        .GRID_W          (W),
        .GRID_H          (H),
        .DEBOUNCE_CYCLES (D)
`ifdef AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_grid;
    bit           m_paused;
    int           m_x;
    int           m_y;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] m);
        bus.btn_left   = m[0];
        bus.btn_right  = m[1];
        bus.btn_up     = m[2];
        bus.btn_down   = m[3];
        bus.btn_toggle = m[4];
        bus.btn_run    = m[5];
        bus.btn_clear  = m[6];
    endtask

    task automatic model_reset();
        m_grid   = '0;
        m_paused = 1'b1;
        m_x      = 0;
        m_y      = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_grid"},   bus.grid_out, m_grid);
        check_val({tag, "_paused"}, bus.paused, m_paused);
        check_val({tag, "_x"},      bus.sel_x, m_x);
        check_val({tag, "_y"},      bus.sel_y, m_y);
        check_val({tag, "_alive"},  bus.cell_alive, m_grid[m_y*W + m_x]);
    endtask

    // Apply one button combination following pattern pat (bit i = level in
    // cycle i), let it settle, then compare against the model.
    task automatic act(input string tag, input logic [6:0] m, input logic [31:0] pat,
                       input int len, input logic [N-1:0] live);
        int pulses = 0;
        int t_snap = -1;
        int t_upd = -1;
        int exp_pulses = 0;
        bit snap_exp = 1'b0;
        bit prev_p;
        bus.live_grid = live;
        prev_p = bus.paused;
        for (int i = 0; i < len + 14; i++) begin
            @(negedge clk);
            if (bus.ctrl_update) begin
                pulses++;
                if (t_upd < 0) t_upd = i;
            end
            if (!prev_p && bus.paused && t_snap < 0) t_snap = i;
            prev_p = bus.paused;
            drive((i < len && pat[i]) ? m : 7'b0);
        end
        if (m[6]) begin
            m_grid = '0;
            m_paused = 1'b1;
            exp_pulses = 1;
        end else if (m[5]) begin
            if (m_paused) begin
                m_paused = 1'b0;
            end else begin
                m_grid = live;
                m_paused = 1'b1;
                exp_pulses = 1;
                snap_exp = 1'b1;
            end
        end else if (m[4] && m_paused) begin
            m_grid[m_y*W + m_x] = ~m_grid[m_y*W + m_x];
            exp_pulses = 1;
        end
        m_x = (m_x + int'(m[1]) - int'(m[0]) + W) % W;
        m_y = (m_y + int'(m[3]) - int'(m[2]) + H) % H;
        check_val({tag, "_pulses"}, pulses, exp_pulses);
        check_outputs(tag);
        if (snap_exp) check_val({tag, "_snap_lag"}, 64'(t_upd - t_snap), 64'd1);
    endtask

    initial begin
        int pulses;
        bit found;
        logic [6:0] m;
        drive(7'b0);
        bus.live_grid = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ctrl_update) pulses++;
        end
        check_val("idle_pulses", pulses, 0);
        check_outputs("reset");

        // Toggle at (0,0), move to (3,2), toggle again
        act("tog0", c_t, c_hold, 6, '0);
        for (int i = 0; i < 3; i++) act("right", c_r, c_hold, 6, '0);
        for (int i = 0; i < 2; i++) act("down", c_d, c_hold, 6, '0);
        act("tog19", c_t, c_hold, 6, '0);
        check_val("bits_0_19", bus.grid_out, 32'h0008_0001);
        check_val("alive_3_2", bus.cell_alive, 1'b1);

        // Wrap-around and cancelling moves
        for (int i = 0; i < 3; i++) act("left", c_l, c_hold, 6, '0);
        act("wrap_left", c_l, c_hold, 6, '0);
        check_val("wrap_x", bus.sel_x, 3'd7);
        for (int i = 0; i < 2; i++) act("up", c_u, c_hold, 6, '0);
        act("wrap_up", c_u, c_hold, 6, '0);
        check_val("wrap_y", bus.sel_y, 2'd3);
        act("lr_cancel", c_l | c_r, c_hold, 6, '0);
        act("diag", c_r | c_d, c_hold, 6, '0);

        // Run, ignored toggle, stop with snapshot
        act("run", c_run, c_hold, 6, '0);
        act("tog_running", c_t, c_hold, 6, 32'h1234_5678);
        act("stop", c_run, c_hold, 6, 32'hA5A5_0F0F);
        check_val("snap_grid", bus.grid_out, 32'hA5A5_0F0F);

        // Bouncing toggle flips once; clear beats run
        act("bounce", c_t, c_bounce, 10, '0);
        act("run2", c_run, c_hold, 6, '0);
        act("clr_run", c_clr | c_run, c_hold, 6, 32'hFFFF_FFFF);
        act("clr_run_p", c_clr | c_run | c_r, c_hold, 6, '0);

        // Reset while in SNAPSHOT
        act("run3", c_run, c_hold, 6, '0);
        bus.live_grid = 32'hDEAD_BEEF;
        drive(c_run);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.paused) begin
                found = 1'b1;
                break;
            end
        end
        check_val("snap_seen", found, 1'b1);
        rst_n = 1'b0;
        drive(7'b0);
        #1;
        model_reset();
        check_val("rst_snap_upd", bus.ctrl_update, 1'b0);
        check_outputs("rst_snap");
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.ctrl_update) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.ctrl_update) pulses++;
        end
        check_val("rst_snap_pulses", pulses, 0);
        check_outputs("after_rst");

`ifdef AUTOREPEAT_EN
        begin
            int offs[$];
            int exp_offs[4];
            logic [2:0] px;
            exp_offs[0] = RD;
            exp_offs[1] = RD + RP;
            exp_offs[2] = RD + 2*RP;
            exp_offs[3] = RD + 3*RP;
            drive(c_r);
            found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.sel_x != 3'(m_x)) begin
                    found = 1'b1;
                    break;
                end
            end
            check_val("ar_first", found, 1'b1);
            px = bus.sel_x;
            for (int k = 1; k <= 50; k++) begin
                @(negedge clk);
                if (k == 36) drive(7'b0);
                if (bus.sel_x != px) begin
                    offs.push_back(k);
                    px = bus.sel_x;
                end
            end
            check_val("ar_count", offs.size(), 4);
            for (int j = 0; j < 4; j++)
                check_val("ar_offset", (j < offs.size()) ? offs[j] : -1, exp_offs[j]);
            m_x = (m_x + 5) % W;
            check_val("ar_x", bus.sel_x, m_x);
        end
`endif

        // Randomised actions
        for (int n = 0; n < 150; n++) begin
            m[0] = ($urandom_range(0, 2) == 0);
            m[1] = ($urandom_range(0, 2) == 0);
            m[2] = ($urandom_range(0, 2) == 0);
            m[3] = ($urandom_range(0, 2) == 0);
            m[4] = ($urandom_range(0, 2) == 0);
            m[5] = ($urandom_range(0, 5) == 0);
            m[6] = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0)
                act("rnd_bounce", m, c_bounce, 10, N'($urandom));
            else
                act("rnd", m, c_hold, 6, N'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
